muntjac_cluster_ctrl: RTL and testbench

Parametrised control block for a multi-hart Muntjac cluster; it sits between the SoC top and NumHarts instances of muntjac_core_wrapper.
- Sequences per-hart reset release: hold after global reset, then release one hart at a time, staggered by a programmable gap.
- Assigns hart IDs.
- Exposes a small register interface so software can enable or disable individual harts.
- Selects and registers one hart's instruction trace for the debug output.

---
 rtl/muntjac_cluster_pkg.sv | 14 +
 rtl/muntjac_pkg.sv | 10 +
 rtl/muntjac_hart_release_seq.sv | 75 +++++++
 rtl/muntjac_cluster_ctrl.sv | 103 ++++++++++
 tb/tb_muntjac_cluster_ctrl.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/muntjac_cluster_pkg.sv
// rtl/muntjac_cluster_pkg.sv - register map and sequencer state encoding
package muntjac_cluster_pkg;

  localparam logic [1:0] REG_ENABLE    = 2'd0;
  localparam logic [1:0] REG_STATUS    = 2'd1;
  localparam logic [1:0] REG_TRACE_SEL = 2'd2;

  typedef enum logic [1:0] {
    SEQ_HOLD = 2'd0,
    SEQ_IDLE = 2'd1,
    SEQ_GAP  = 2'd2
  } seq_state_e;

endpackage

// File: rtl/muntjac_pkg.sv
// rtl/muntjac_pkg.sv - core-level shared types used by the cluster controller
package muntjac_pkg;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] insn;
  } instr_trace_t;

endpackage

// File: rtl/muntjac_hart_release_seq.sv
// rtl/muntjac_hart_release_seq.sv - staggered per-hart reset release sequencer
module muntjac_hart_release_seq
  import muntjac_cluster_pkg::*;
#(
  parameter int unsigned NumHarts        = 4,
  parameter int unsigned ResetHoldCycles = 16,
  parameter int unsigned StaggerCycles   = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NumHarts-1:0] enable,
  input  logic [NumHarts-1:0] clr,
  output logic [NumHarts-1:0] released
);

  seq_state_e          state_q, state_d;
  logic [31:0]         cnt_q, cnt_d;
  logic [NumHarts-1:0] released_q;
  logic [NumHarts-1:0] pending;
  logic [NumHarts-1:0] pick;
  logic [NumHarts-1:0] set;
  logic                found;

  assign pending  = enable & ~released_q;
  assign released = released_q;

  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < int'(NumHarts); i++) begin
      if (pending[i] && !found) begin
        pick[i] = 1'b1;
        found   = 1'b1;
      end
    end
  end

  // Counter exits on reaching 1 so that IDLE plus GAP span exactly StaggerCycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    set     = '0;
    case (state_q)
      SEQ_HOLD: begin
        if (cnt_q <= 32'd1) state_d = SEQ_IDLE;
        else                cnt_d   = cnt_q - 32'd1;
      end
      SEQ_IDLE: begin
        if (|pending) begin
          set     = pick;
          cnt_d   = 32'(StaggerCycles - 1);
          state_d = (StaggerCycles > 1) ? SEQ_GAP : SEQ_IDLE;
        end
      end
      SEQ_GAP: begin
        if (cnt_q <= 32'd1) state_d = SEQ_IDLE;
        else                cnt_d   = cnt_q - 32'd1;
      end
      default: state_d = SEQ_HOLD;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= SEQ_HOLD;
      cnt_q      <= 32'(ResetHoldCycles - 1);
      released_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      released_q <= (released_q | set) & ~clr;
    end
  end

endmodule

// File: rtl/muntjac_cluster_ctrl.sv
// rtl/muntjac_cluster_ctrl.sv - multi-hart cluster reset sequencing, hart IDs, registers and trace select
module muntjac_cluster_ctrl
  import muntjac_pkg::*;
  import muntjac_cluster_pkg::*;
#(
  parameter int unsigned NumHarts        = 4,
  parameter logic [31:0] BootMask        = 32'h1,
  parameter int unsigned ResetHoldCycles = 16,
  parameter int unsigned StaggerCycles   = 8,
  parameter logic [63:0] HartIdBase      = 64'h0
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           cfg_valid_i,
  output logic                           cfg_ready_o,
  input  logic                           cfg_we_i,
  input  logic [1:0]                     cfg_addr_i,
  input  logic [31:0]                    cfg_wdata_i,
  output logic                           cfg_rvalid_o,
  output logic [31:0]                    cfg_rdata_o,
  output logic                           cfg_err_o,
  output logic [NumHarts-1:0]            hart_rst_no,
  output logic [NumHarts-1:0][63:0]      hart_id_o,
  input  instr_trace_t [NumHarts-1:0]    dbg_i,
  output instr_trace_t                   dbg_o
);

  logic [NumHarts-1:0] enable_q;
  logic [NumHarts-1:0] released;
  logic [NumHarts-1:0] en_clr;
  logic [4:0]          trace_sel_q;
  logic                wr_enable;
  logic                unused_wdata;
  instr_trace_t        dbg_sel;

  assign cfg_ready_o  = 1'b1;
  assign unused_wdata = ^cfg_wdata_i;
  assign wr_enable    = cfg_valid_i && cfg_we_i && (cfg_addr_i == REG_ENABLE);
  // Bits being cleared by this write drop their release on the same edge.
  assign en_clr       = wr_enable ? (enable_q & ~cfg_wdata_i[NumHarts-1:0]) : '0;
  assign hart_rst_no  = released;

  for (genvar i = 0; i < int'(NumHarts); i++) begin : g_hart_id
    assign hart_id_o[i] = HartIdBase + 64'(i);
  end

  muntjac_hart_release_seq #(
    .NumHarts        (NumHarts),
    .ResetHoldCycles (ResetHoldCycles),
    .StaggerCycles   (StaggerCycles)
  ) u_seq (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .enable   (enable_q),
    .clr      (en_clr),
    .released (released)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      enable_q     <= BootMask[NumHarts-1:0];
      trace_sel_q  <= '0;
      cfg_rvalid_o <= 1'b0;
      cfg_rdata_o  <= '0;
      cfg_err_o    <= 1'b0;
    end else begin
      cfg_rvalid_o <= cfg_valid_i;
      cfg_rdata_o  <= '0;
      cfg_err_o    <= 1'b0;
      if (cfg_valid_i) begin
        case (cfg_addr_i)
          REG_ENABLE: begin
            if (cfg_we_i) enable_q    <= cfg_wdata_i[NumHarts-1:0];
            else          cfg_rdata_o <= 32'(enable_q);
          end
          REG_STATUS: begin
            if (cfg_we_i) cfg_err_o   <= 1'b1;
            else          cfg_rdata_o <= 32'(released);
          end
          REG_TRACE_SEL: begin
            if (cfg_we_i) trace_sel_q <= cfg_wdata_i[4:0];
            else          cfg_rdata_o <= 32'(trace_sel_q);
          end
          default: cfg_err_o <= 1'b1;
        endcase
      end
    end
  end

  // Explicit compare loop keeps out-of-range selects returning zero.
  always_comb begin
    dbg_sel = '0;
    for (int i = 0; i < int'(NumHarts); i++) begin
      if (trace_sel_q == 5'(i)) dbg_sel = dbg_i[i];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) dbg_o <= '0;
    else         dbg_o <= dbg_sel;
  end

endmodule

// File: tb/tb_muntjac_cluster_ctrl.sv
// tb/tb_muntjac_cluster_ctrl.sv - directed self-checking bench for muntjac_cluster_ctrl
module tb_muntjac_cluster_ctrl;
  import muntjac_pkg::*;

  logic                 clk_i = 1'b0;
  logic                 rst_ni;
  logic                 cfg_valid_i;
  logic                 cfg_ready_o;
  logic                 cfg_we_i;
  logic [1:0]           cfg_addr_i;
  logic [31:0]          cfg_wdata_i;
  logic                 cfg_rvalid_o;
  logic [31:0]          cfg_rdata_o;
  logic                 cfg_err_o;
  logic [3:0]           hart_rst_no;
  logic [3:0][63:0]     hart_id_o;
  instr_trace_t [3:0]   dbg_i;
  instr_trace_t         dbg_o;

  int compared   = 0;
  int mismatched = 0;

  muntjac_cluster_ctrl #(
    .NumHarts        (4),
    .BootMask        (32'h5),
    .ResetHoldCycles (16),
    .StaggerCycles   (8),
    .HartIdBase      (64'h0)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .cfg_valid_i  (cfg_valid_i),
    .cfg_ready_o  (cfg_ready_o),
    .cfg_we_i     (cfg_we_i),
    .cfg_addr_i   (cfg_addr_i),
    .cfg_wdata_i  (cfg_wdata_i),
    .cfg_rvalid_o (cfg_rvalid_o),
    .cfg_rdata_o  (cfg_rdata_o),
    .cfg_err_o    (cfg_err_o),
    .hart_rst_no  (hart_rst_no),
    .hart_id_o    (hart_id_o),
    .dbg_i        (dbg_i),
    .dbg_o        (dbg_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Caller is at a negedge; returns at the negedge after acceptance.
  task automatic cfg_access(input logic we, input logic [1:0] addr, input logic [31:0] wdata);
    cfg_valid_i = 1'b1;
    cfg_we_i    = we;
    cfg_addr_i  = addr;
    cfg_wdata_i = wdata;
    @(posedge clk_i);
    @(negedge clk_i);
    cfg_valid_i = 1'b0;
    cfg_we_i    = 1'b0;
    cfg_wdata_i = '0;
  endtask

  // Release reset and follow hold then staggered release for BootMask 4'b0101.
  task automatic boot_and_check();
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk_i);
      chk("hold", 128'(hart_rst_no), 128'h0);
    end
    @(negedge clk_i);
    chk("boot_h0", 128'(hart_rst_no), 128'h1);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk_i);
      chk("boot_gap", 128'(hart_rst_no), 128'h1);
    end
    @(negedge clk_i);
    chk("boot_h2", 128'(hart_rst_no), 128'h5);
    for (int i = 0; i < 10; i++) @(negedge clk_i);
    chk("boot_stable", 128'(hart_rst_no), 128'h5);
  endtask

  initial begin
    rst_ni      = 1'b0;
    cfg_valid_i = 1'b0;
    cfg_we_i    = 1'b0;
    cfg_addr_i  = '0;
    cfg_wdata_i = '0;
    for (int i = 0; i < 4; i++) begin
      dbg_i[i].valid = 1'b1;
      dbg_i[i].pc    = 32'h1000 + 32'(i * 4);
      dbg_i[i].insn  = 32'hA0 + 32'(i);
    end

    repeat (3) @(negedge clk_i);
    chk("rst_hart", 128'(hart_rst_no), 128'h0);
    chk("rst_rvalid", 128'(cfg_rvalid_o), 128'h0);
    chk("rst_rdata", 128'(cfg_rdata_o), 128'h0);
    chk("rst_err", 128'(cfg_err_o), 128'h0);
    chk("rst_dbg", 128'(dbg_o), 128'h0);
    chk("ready", 128'(cfg_ready_o), 128'h1);
    chk("hart_id3", 128'(hart_id_o[3]), 128'h3);
    chk("hart_id1", 128'(hart_id_o[1]), 128'h1);

    boot_and_check();
    cfg_access(1'b0, 2'd1, 32'h0);
    chk("status_boot_rv", 128'(cfg_rvalid_o), 128'h1);
    chk("status_boot", 128'(cfg_rdata_o), 128'h5);
    cfg_access(1'b0, 2'd0, 32'h0);
    chk("enable_boot", 128'(cfg_rdata_o), 128'h5);

    // Enable all: hart 1 then hart 3, eight cycles apart.
    cfg_access(1'b1, 2'd0, 32'hF);
    chk("wr_rvalid", 128'(cfg_rvalid_o), 128'h1);
    chk("wr_err", 128'(cfg_err_o), 128'h0);
    chk("wr_rdata", 128'(cfg_rdata_o), 128'h0);
    @(negedge clk_i);
    chk("en_h1", 128'(hart_rst_no), 128'h7);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk_i);
      chk("en_gap", 128'(hart_rst_no), 128'h7);
    end
    @(negedge clk_i);
    chk("en_h3", 128'(hart_rst_no), 128'hF);
    cfg_access(1'b0, 2'd1, 32'h0);
    chk("status_all", 128'(cfg_rdata_o), 128'hF);

    // Disable 3..1 takes effect the cycle after acceptance.
    cfg_access(1'b1, 2'd0, 32'h1);
    chk("disable", 128'(hart_rst_no), 128'h1);
    for (int i = 0; i < 10; i++) @(negedge clk_i);
    chk("disable_hold", 128'(hart_rst_no), 128'h1);

    // Clear hart 1 on the very cycle IDLE selects it, then re-enable.
    cfg_access(1'b1, 2'd0, 32'h3);
    cfg_access(1'b1, 2'd0, 32'h1);
    chk("race_clear", 128'(hart_rst_no), 128'h1);
    cfg_access(1'b1, 2'd0, 32'h3);
    chk("race_reen", 128'(hart_rst_no), 128'h1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      chk("race_gap", 128'(hart_rst_no), 128'h1);
    end
    @(negedge clk_i);
    chk("race_rel", 128'(hart_rst_no), 128'h3);

    // Error responses.
    cfg_access(1'b1, 2'd1, 32'hFFFF_FFFF);
    chk("st_wr_rv", 128'(cfg_rvalid_o), 128'h1);
    chk("st_wr_err", 128'(cfg_err_o), 128'h1);
    chk("st_wr_noeff", 128'(hart_rst_no), 128'h3);
    cfg_access(1'b0, 2'd3, 32'h0);
    chk("rsv_rd_err", 128'(cfg_err_o), 128'h1);
    chk("rsv_rd_data", 128'(cfg_rdata_o), 128'h0);
    cfg_access(1'b1, 2'd3, 32'h1234);
    chk("rsv_wr_err", 128'(cfg_err_o), 128'h1);
    cfg_access(1'b0, 2'd0, 32'h0);
    chk("enable_rd_err", 128'(cfg_err_o), 128'h0);
    chk("enable_rd", 128'(cfg_rdata_o), 128'h3);
    @(negedge clk_i);
    chk("rvalid_drop", 128'(cfg_rvalid_o), 128'h0);

    // Trace select.
    cfg_access(1'b1, 2'd2, 32'h2);
    chk("trace_old", 128'(dbg_o), {63'h0, 1'b1, 32'h1000, 32'hA0});
    @(negedge clk_i);
    chk("trace_h2", 128'(dbg_o), {63'h0, 1'b1, 32'h1008, 32'hA2});
    cfg_access(1'b0, 2'd2, 32'h0);
    chk("trace_sel_rd", 128'(cfg_rdata_o), 128'h2);
    cfg_access(1'b1, 2'd2, 32'h7);
    @(negedge clk_i);
    chk("trace_oor", 128'(dbg_o), 128'h0);

    // Reset in the middle of a stagger gap.
    cfg_access(1'b1, 2'd0, 32'hF);
    @(negedge clk_i);
    chk("pre_rst_h2", 128'(hart_rst_no), 128'h7);
    cfg_access(1'b0, 2'd1, 32'h0);
    chk("pre_rst_rv", 128'(cfg_rvalid_o), 128'h1);
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_hart", 128'(hart_rst_no), 128'h0);
    chk("mid_rst_rv", 128'(cfg_rvalid_o), 128'h0);
    chk("mid_rst_dbg", 128'(dbg_o), 128'h0);
    repeat (2) @(negedge clk_i);
    boot_and_check();
    cfg_access(1'b0, 2'd0, 32'h0);
    chk("enable_reboot", 128'(cfg_rdata_o), 128'h5);
    cfg_access(1'b0, 2'd2, 32'h0);
    chk("trace_sel_reboot", 128'(cfg_rdata_o), 128'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
